// File: rtl/smem_arb_pkg.sv
// smem_arb_pkg: shared constants for the result-queue output arbiter (FSM encoding, FIFO depth, widths)
package smem_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int FIFO_DEPTH     = 2;
    localparam int DATA_W_DEF     = 512;
    localparam int READ_NUM_WIDTH = 32;

endpackage

// File: rtl/smem_rr_pick.sv
// smem_rr_pick: combinational round-robin picker, first eligible index at or after ptr, wrapping
module smem_rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    // scan from the farthest offset down so the nearest eligible slot is written last and wins
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (eligible[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/smem_output_arbiter.sv
// smem_output_arbiter: round-robin share of the host write path between result-queue instances
// Optional per-requester beat counters are built when SMEM_ARB_PERF_CNT_EN is defined.
module smem_output_arbiter
    import smem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int BEAT_CNT_W = 16,
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          batch_start,
    input  logic [NUM_REQ-1:0]            req_request,
    output logic [NUM_REQ-1:0]            req_permit,
    output logic [NUM_REQ-1:0]            req_stall,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_finish,
    output logic [DATA_W-1:0]             host_data,
    output logic                          host_valid,
    input  logic                          host_ready,
    output logic [IDX_W-1:0]              grant_id,
    output logic                          all_done,
    output logic [NUM_REQ*BEAT_CNT_W-1:0] perf_beats
);

    logic [1:0]         state;
    logic [NUM_REQ-1:0] done;
    logic [NUM_REQ-1:0] win;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               busy;
    logic               finish;
    logic               push;
    logic               pop;
    logic [DATA_W-1:0]  mem [FIFO_DEPTH];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         count;

    smem_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .eligible (req_request & ~done),
        .ptr      (rr_ptr),
        .idx      (pick_idx),
        .any      (pick_any)
    );

    assign busy       = state == ST_BUSY;
    assign win        = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
    assign finish     = busy && req_finish[grant_id];
    assign push       = busy && req_valid[grant_id];
    assign pop        = host_valid && host_ready;
    assign host_valid = count != 2'd0;
    assign host_data  = mem[rd_ptr];
    assign req_permit = busy ? win : '0;
    // the one beat in flight when stall is seen must still fit, hence stall already at one entry without a pop
    assign req_stall  = (busy && (count == 2'd2 || (count == 2'd1 && !host_ready))) ? win : '0;

    // grant FSM, done mask and registered all_done; batch_start clear beats a same-cycle finish
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            done     <= '0;
            all_done <= 1'b0;
        end else begin
            all_done <= !batch_start && (&done) && count == 2'd0 && state == ST_IDLE;
            done     <= batch_start ? '0 : finish ? (done | win) : done;
            if (state == ST_IDLE && pick_any) begin
                grant_id <= pick_idx;
                state    <= ST_BUSY;
            end
            if (finish) begin
                state  <= ST_DRAIN;
                rr_ptr <= (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
            if (state == ST_DRAIN && count == 2'd0) state <= ST_IDLE;
        end
    end

    // two-entry FIFO toward the host; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= req_data[grant_id*DATA_W +: DATA_W];
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) !(push && !pop && count == 2'd2));

`ifdef SMEM_ARB_PERF_CNT_EN
    logic [BEAT_CNT_W-1:0] beats [NUM_REQ];

    // saturating beat counters, one per requester
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REQ; i++) beats[i] <= '0;
        end else if (batch_start) begin
            for (int i = 0; i < NUM_REQ; i++) beats[i] <= '0;
        end else if (push && beats[grant_id] != '1) begin
            beats[grant_id] <= beats[grant_id] + 1'b1;
        end
    end

    // flatten counters onto the output bus
    always_comb begin
        perf_beats = '0;
        for (int i = 0; i < NUM_REQ; i++) perf_beats[i*BEAT_CNT_W +: BEAT_CNT_W] = beats[i];
    end
`else
    assign perf_beats = '0;
`endif

endmodule
